// File: rtl/end_game_receiver.sv
// End-of-game frame decoder: header byte EVENT_CODE followed by one payload byte {victory, points[6:0]}.
// Optional payload timeout is built only when RX_TIMEOUT_EN is defined.
module end_game_receiver #(
  parameter logic [7:0]  EVENT_CODE     = 8'hAE,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dado_recebido,
  input  logic       recebido_valido,
  output logic [6:0] points,
  output logic       victory_condition,
  output logic       evento_recebido,
  output logic       erro_timeout,
  output logic       ocupado,
  output logic [7:0] quadros_recebidos
);

  typedef enum logic {IDLE, WAIT_PAYLOAD} state_t;

  state_t state, state_nxt;

  logic       hdr_hit;
  logic       payload_take;
  logic       timeout_hit;

  logic [6:0] points_d;
  logic       victory_d;
  logic       evento_d;
  logic       erro_d;
  logic       ocupado_d;
  logic [7:0] quadros_d;

  assign hdr_hit      = (state == IDLE) && recebido_valido && (dado_recebido == EVENT_CODE);
  assign payload_take = (state == WAIT_PAYLOAD) && recebido_valido;

`ifdef RX_TIMEOUT_EN
  logic [31:0] timer;

  // Timer only advances on idle cycles in WAIT_PAYLOAD; a strobe on the expiry cycle wins.
  assign timeout_hit = (state == WAIT_PAYLOAD) && !recebido_valido &&
                       (timer == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      timer <= '0;
    else if (state != WAIT_PAYLOAD || recebido_valido || timeout_hit)
      timer <= '0;
    else
      timer <= timer + 32'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (hdr_hit) state_nxt = WAIT_PAYLOAD;
      WAIT_PAYLOAD: if (payload_take || timeout_hit) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    points_d  = points;
    victory_d = victory_condition;
    quadros_d = quadros_recebidos;
    evento_d  = 1'b0;
    erro_d    = 1'b0;
    if (payload_take) begin
      points_d  = dado_recebido[6:0];
      victory_d = dado_recebido[7];
      quadros_d = quadros_recebidos + 8'd1;
      evento_d  = 1'b1;
    end
    if (timeout_hit) erro_d = 1'b1;
    ocupado_d = (state_nxt == WAIT_PAYLOAD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      points            <= '0;
      victory_condition <= 1'b0;
      evento_recebido   <= 1'b0;
      ocupado           <= 1'b0;
      quadros_recebidos <= '0;
    end else begin
      points            <= points_d;
      victory_condition <= victory_d;
      evento_recebido   <= evento_d;
      ocupado           <= ocupado_d;
      quadros_recebidos <= quadros_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) erro_timeout <= 1'b0;
    else        erro_timeout <= erro_d;
  end
`else
  assign erro_timeout = 1'b0;
  logic unused_erro;
  assign unused_erro = erro_d;
`endif

endmodule
